// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg / pipeline_hazard_controller
//
// Central sequencer for the 5-stage pipeline. It decides, every cycle, what each
// inter-stage register does (load, hold, or clear to a bubble) and whether the
// PC advances. The decision draws on these inputs:
//   - instruction/data cache completion (ihit, dhit)
//   - load-use hazards between EX and ID
//   - branch redirects resolved in MEM
//   - halt
// A small FSM remembers an outstanding data access (MEMWAIT) and the halted
// condition (HALTED). Two saturating performance counters track stall cycles
// and branch flushes.
//
// Ports:
//   CLK, nRST           clock (rising edge), asynchronous active-low reset
//   ihit, dhit          fetch / data access complete this cycle
//   dREN_mem, dWEN_mem  load / store in MEM
//   branch_taken_mem    MEM-stage branch/jump redirects the PC
//   halt_mem            halt instruction in MEM
//   MemToReg_ex         load in EX
//   regWSEL_ex          EX destination register
//   rs_id, rt_id        ID source registers
//   fd/de/em/mw_state   per-register control (pipe_state_t)
//   pc_en               PC load enable
//   halt                registered halt to the system
//   stall_cycles        saturating count of cycles with pc_en=0 outside HALTED
//   flush_count         saturating count of branch flushes
// -----------------------------------------------------------------------------
package cpu_types_pkg;
  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'b00,  // load
    PIPE_STALL  = 2'b01,  // hold
    PIPE_NOP    = 2'b10   // clear to bubble
  } pipe_state_t;
endpackage

module pipeline_hazard_controller
  import cpu_types_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int NUM_REGS_W = 5
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  ihit,
  input  logic                  dhit,
  input  logic                  dREN_mem,
  input  logic                  dWEN_mem,
  input  logic                  branch_taken_mem,
  input  logic                  halt_mem,
  input  logic                  MemToReg_ex,
  input  logic [NUM_REGS_W-1:0] regWSEL_ex,
  input  logic [NUM_REGS_W-1:0] rs_id,
  input  logic [NUM_REGS_W-1:0] rt_id,
  output pipe_state_t           fd_state,
  output pipe_state_t           de_state,
  output pipe_state_t           em_state,
  output pipe_state_t           mw_state,
  output logic                  pc_en,
  output logic                  halt,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    HALTED  = 2'b10
  } fsm_t;

  fsm_t state, next_state;

  logic memop;
  logic luhaz;
  logic halt_fire;   // rule 3 taken this cycle
  logic flush_fire;  // rule 4 taken this cycle
  logic stall_inc;

  assign memop = dREN_mem | dWEN_mem;

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign luhaz = MemToReg_ex && (regWSEL_ex != '0) &&
                 ((regWSEL_ex == rs_id) || (regWSEL_ex == rt_id));

  // Priority-ordered control decode; the first matching condition wins.
  always_comb begin
    // NOTE: every signal gets a default before the if-chain, so no path leaves
    // a value unassigned and no latch is inferred.
    fd_state   = PIPE_ENABLE;
    de_state   = PIPE_ENABLE;
    em_state   = PIPE_ENABLE;
    mw_state   = PIPE_ENABLE;
    pc_en      = 1'b1;
    next_state = state;
    halt_fire  = 1'b0;
    flush_fire = 1'b0;

    if (!nRST) begin
      // Hold every register cleared while reset is asserted.
      fd_state = PIPE_NOP;
      de_state = PIPE_NOP;
      em_state = PIPE_NOP;
      mw_state = PIPE_NOP;
      pc_en    = 1'b0;
    end else if (state == HALTED) begin
      // Frozen: ignores every input until reset.
      fd_state = PIPE_STALL;
      de_state = PIPE_STALL;
      em_state = PIPE_STALL;
      mw_state = PIPE_NOP;
      pc_en    = 1'b0;
    end else if (memop && !dhit) begin
      // Data access outstanding: hold the front of the pipe and keep the
      // unfinished op out of MEM/WB so it retires only once, on the dhit cycle.
      fd_state   = PIPE_STALL;
      de_state   = PIPE_STALL;
      em_state   = PIPE_STALL;
      mw_state   = PIPE_NOP;
      pc_en      = 1'b0;
      next_state = MEMWAIT;
    end else begin
      // Any data access has completed (or there was none): back to RUN.
      next_state = RUN;
      if (halt_mem) begin
        fd_state   = PIPE_NOP;
        de_state   = PIPE_NOP;
        em_state   = PIPE_NOP;
        pc_en      = 1'b0;
        halt_fire  = 1'b1;
        next_state = HALTED;
      end else if (branch_taken_mem) begin
        // Redirect squashes everything younger, including a load-use victim,
        // and proceeds even if the current fetch has not completed.
        fd_state   = PIPE_NOP;
        de_state   = PIPE_NOP;
        em_state   = PIPE_NOP;
        flush_fire = 1'b1;
      end else if (luhaz) begin
        fd_state = PIPE_STALL;
        de_state = PIPE_NOP;
        pc_en    = 1'b0;
      end else if (!ihit) begin
        fd_state = PIPE_NOP;
        pc_en    = 1'b0;
      end
    end
  end

  assign stall_inc = !pc_en && (state != HALTED);

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= RUN;
      halt         <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= next_state;
      if (halt_fire) begin
        halt <= 1'b1;
      end
      if (stall_inc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_fire && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for pipeline_hazard_controller.
// Inputs change 1 time unit after the rising edge. Combinational outputs are
// sampled mid-cycle and registered outputs just after the edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

  localparam int CNT_W = 16;
  localparam int RW    = 5;

  localparam logic [1:0] EN = 2'b00;
  localparam logic [1:0] ST = 2'b01;
  localparam logic [1:0] NP = 2'b10;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            ihit, dhit, dREN_mem, dWEN_mem;
  logic            branch_taken_mem, halt_mem, MemToReg_ex;
  logic [RW-1:0]   regWSEL_ex, rs_id, rt_id;
  logic [1:0]      fd_state, de_state, em_state, mw_state;
  logic            pc_en, halt;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Bench-side expected counter values.
  logic [CNT_W-1:0] exp_stall;
  logic [CNT_W-1:0] exp_flush;

  pipeline_hazard_controller #(.CNT_W(CNT_W), .NUM_REGS_W(RW)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .ihit             (ihit),
    .dhit             (dhit),
    .dREN_mem         (dREN_mem),
    .dWEN_mem         (dWEN_mem),
    .branch_taken_mem (branch_taken_mem),
    .halt_mem         (halt_mem),
    .MemToReg_ex      (MemToReg_ex),
    .regWSEL_ex       (regWSEL_ex),
    .rs_id            (rs_id),
    .rt_id            (rt_id),
    .fd_state         (fd_state),
    .de_state         (de_state),
    .em_state         (em_state),
    .mw_state         (mw_state),
    .pc_en            (pc_en),
    .halt             (halt),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
  );

  always #5 CLK = ~CLK;

  // Packed view of all combinational controls: {fd, de, em, mw, pc_en}.
  function automatic logic [8:0] ctl();
    return {fd_state, de_state, em_state, mw_state, pc_en};
  endfunction

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0;
    branch_taken_mem = 1'b0; halt_mem = 1'b0; MemToReg_ex = 1'b0;
    regWSEL_ex = '0; rs_id = '0; rt_id = '0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    idle();
    nRST = 1'b0;
    #2;
    tests_run++;
    if ({ctl(), halt} !== {NP, NP, NP, NP, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_ctl: got ctl=%b halt=%b want ctl=101010100 halt=0", ctl(), halt);
    end
    tests_run++;
    if ({stall_cycles, flush_count} !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_cnt: got stall=%h flush=%h want 0/0", stall_cycles, flush_count);
    end
    @(negedge CLK);
    nRST = 1'b1;
    exp_stall = '0;
    exp_flush = '0;
    #1;
    tests_run++;
    if (ctl() !== {EN, EN, EN, EN, 1'b1}) begin
      tests_failed++;
      $display("FAIL release_ctl: got %b want 000000001", ctl());
    end
    repeat (3) step();
    tests_run++;
    if ({stall_cycles, flush_count, halt} !== {exp_stall, exp_flush, 1'b0}) begin
      tests_failed++;
      $display("FAIL release_cnt: got stall=%h flush=%h halt=%b want 0/0/0",
               stall_cycles, flush_count, halt);
    end
  endtask

  task automatic test_memwait();
    idle();
    dREN_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      tests_run++;
      if (ctl() !== {ST, ST, ST, NP, 1'b0}) begin
        tests_failed++;
        $display("FAIL memwait_stall[%0d]: got %b want 010101100", i, ctl());
      end
      step();
      exp_stall++;
    end
    dhit = 1'b1;
    settle();
    tests_run++;
    if (ctl() !== {EN, EN, EN, EN, 1'b1}) begin
      tests_failed++;
      $display("FAIL memwait_done: got %b want 000000001", ctl());
    end
    step();
    tests_run++;
    if (stall_cycles !== exp_stall) begin
      tests_failed++;
      $display("FAIL memwait_cnt: got %h want %h", stall_cycles, exp_stall);
    end
    // Store hitting immediately in RUN passes with no stall.
    dREN_mem = 1'b0; dWEN_mem = 1'b1; dhit = 1'b1;
    settle();
    tests_run++;
    if (ctl() !== {EN, EN, EN, EN, 1'b1}) begin
      tests_failed++;
      $display("FAIL store_hit: got %b want 000000001", ctl());
    end
    step();
    idle();
  endtask

  task automatic test_load_use();
    idle();
    MemToReg_ex = 1'b1; regWSEL_ex = 5'd5; rt_id = 5'd5; rs_id = 5'd3;
    settle();
    tests_run++;
    if (ctl() !== {ST, NP, EN, EN, 1'b0}) begin
      tests_failed++;
      $display("FAIL luhaz_rt: got %b want 011000000", ctl());
    end
    step();
    exp_stall++;
    regWSEL_ex = 5'd7; rs_id = 5'd7; rt_id = 5'd1;
    settle();
    tests_run++;
    if (ctl() !== {ST, NP, EN, EN, 1'b0}) begin
      tests_failed++;
      $display("FAIL luhaz_rs: got %b want 011000000", ctl());
    end
    step();
    exp_stall++;
    regWSEL_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    settle();
    tests_run++;
    if (ctl() !== {EN, EN, EN, EN, 1'b1}) begin
      tests_failed++;
      $display("FAIL luhaz_r0: got %b want 000000001", ctl());
    end
    step();
    idle();
    ihit = 1'b0;
    settle();
    tests_run++;
    if (ctl() !== {NP, EN, EN, EN, 1'b0}) begin
      tests_failed++;
      $display("FAIL imiss: got %b want 100000000", ctl());
    end
    step();
    exp_stall++;
    tests_run++;
    if (stall_cycles !== exp_stall) begin
      tests_failed++;
      $display("FAIL luhaz_cnt: got %h want %h", stall_cycles, exp_stall);
    end
    idle();
  endtask

  task automatic test_branch_flush();
    idle();
    branch_taken_mem = 1'b1; ihit = 1'b0;
    MemToReg_ex = 1'b1; regWSEL_ex = 5'd5; rt_id = 5'd5;
    settle();
    tests_run++;
    if (ctl() !== {NP, NP, NP, EN, 1'b1}) begin
      tests_failed++;
      $display("FAIL flush_prio: got %b want 101010001", ctl());
    end
    step();
    exp_flush++;
    tests_run++;
    if ({flush_count, stall_cycles} !== {exp_flush, exp_stall}) begin
      tests_failed++;
      $display("FAIL flush_cnt: got flush=%h stall=%h want %h/%h",
               flush_count, stall_cycles, exp_flush, exp_stall);
    end
    // Outstanding load outranks a branch; the branch then fires on dhit.
    idle();
    dREN_mem = 1'b1; branch_taken_mem = 1'b1;
    settle();
    tests_run++;
    if (ctl() !== {ST, ST, ST, NP, 1'b0}) begin
      tests_failed++;
      $display("FAIL mem_over_branch: got %b want 010101100", ctl());
    end
    step();
    exp_stall++;
    dhit = 1'b1;
    settle();
    tests_run++;
    if (ctl() !== {NP, NP, NP, EN, 1'b1}) begin
      tests_failed++;
      $display("FAIL branch_on_dhit: got %b want 101010001", ctl());
    end
    step();
    exp_flush++;
    tests_run++;
    if ({flush_count, stall_cycles} !== {exp_flush, exp_stall}) begin
      tests_failed++;
      $display("FAIL branch_dhit_cnt: got flush=%h stall=%h want %h/%h",
               flush_count, stall_cycles, exp_flush, exp_stall);
    end
    idle();
  endtask

  task automatic test_halt();
    idle();
    halt_mem = 1'b1;
    settle();
    tests_run++;
    if ({ctl(), halt} !== {NP, NP, NP, EN, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL halt_fire: got ctl=%b halt=%b want 101010000/0", ctl(), halt);
    end
    step();
    exp_stall++;
    tests_run++;
    if (halt !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_reg: got %b want 1", halt);
    end
    // Toggle inputs; HALTED must ignore all of them.
    for (int i = 0; i < 4; i++) begin
      idle();
      ihit = i[0]; branch_taken_mem = i[1]; dREN_mem = ~i[0]; dhit = i[1];
      halt_mem = i[0] ^ i[1];
      settle();
      tests_run++;
      if ({ctl(), halt} !== {ST, ST, ST, NP, 1'b0, 1'b1}) begin
        tests_failed++;
        $display("FAIL halted_hold[%0d]: got ctl=%b halt=%b want 010101100/1", i, ctl(), halt);
      end
      step();
    end
    tests_run++;
    if ({stall_cycles, flush_count} !== {exp_stall, exp_flush}) begin
      tests_failed++;
      $display("FAIL halted_cnt: got stall=%h flush=%h want %h/%h",
               stall_cycles, flush_count, exp_stall, exp_flush);
    end
    idle();
    nRST = 1'b0;
    #2;
    tests_run++;
    if ({halt, stall_cycles, flush_count} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL halt_reset: got halt=%b stall=%h flush=%h want 0/0/0",
               halt, stall_cycles, flush_count);
    end
    nRST = 1'b1;
    exp_stall = '0;
    exp_flush = '0;
    settle();
    tests_run++;
    if (ctl() !== {EN, EN, EN, EN, 1'b1}) begin
      tests_failed++;
      $display("FAIL halt_rerun: got %b want 000000001", ctl());
    end
    step();
  endtask

  task automatic test_saturation();
    idle();
    ihit = 1'b0;
    repeat (16'hFFFE - int'(exp_stall)) begin
      step();
      exp_stall++;
    end
    tests_run++;
    if (stall_cycles !== 16'hFFFE) begin
      tests_failed++;
      $display("FAIL sat_pre: got %h want fffe", stall_cycles);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (stall_cycles !== 16'hFFFF) begin
        tests_failed++;
        $display("FAIL sat_hold[%0d]: got %h want ffff", i, stall_cycles);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_memwait();
    test_load_use();
    test_branch_flush();
    test_halt();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
